// File: rtl/input_port_buffer.sv
// Per-port input flit FIFO feeding the crossbar: show-ahead head flit,
// registered credit return per pop, and a sticky overflow flag for dropped flits.
module input_port_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [16:0]      data_i,
    input  logic             pop_i,
    output logic [16:0]      data_o,
    output logic             credit_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [16:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_credit;
    logic             r_overflow;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;
    logic w_drop;

    always_comb begin
        w_full    = (r_count == CNT_W'(DEPTH));
        w_empty   = (r_count == '0);
        w_do_pop  = pop_i && !w_empty;
        // A push into a full FIFO is only safe when a pop frees the head slot this edge.
        w_do_push = data_i[16] && (!w_full || w_do_pop);
        w_drop    = data_i[16] && w_full && !w_do_pop;
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_credit   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_credit <= w_do_pop;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        data_o     = w_empty ? '0 : r_mem[r_rd_ptr];
        credit_o   = r_credit;
        count_o    = r_count;
        full_o     = w_full;
        empty_o    = w_empty;
        overflow_o = r_overflow;
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed vector table plus a
// queue scoreboard for wrap-around ordering and credit accounting.
module tb_input_port_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk;
    logic             rst;
    logic [16:0]      data_i;
    logic             pop_i;
    logic [16:0]      data_o;
    logic             credit_o;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             empty_o;
    logic             overflow_o;

    int n_tests;
    int n_fail;

    input_port_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .pop_i      (pop_i),
        .data_o     (data_o),
        .credit_o   (credit_o),
        .count_o    (count_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (act=running, exp=finished)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [16:0] d;
        logic        pop;
        logic [16:0] e_data;
        logic [2:0]  e_cnt;
        logic        e_cr;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [15];
    logic [16:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h exp=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic [16:0] d, input logic p);
        data_i = d;
        pop_i  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(17'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [16:0] ed, input logic [2:0] ec,
                             input logic ecr, input logic ef, input logic ee, input logic eo);
        chk({tag, ".data"},  32'(data_o),     32'(ed));
        chk({tag, ".count"}, 32'(count_o),    32'(ec));
        chk({tag, ".credit"},32'(credit_o),   32'(ecr));
        chk({tag, ".full"},  32'(full_o),     32'(ef));
        chk({tag, ".empty"}, 32'(empty_o),    32'(ee));
        chk({tag, ".ovf"},   32'(overflow_o), 32'(eo));
    endtask

    initial begin
        int credits;
        int pops;
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        data_i  = '0;
        pop_i   = 1'b0;

        //            d          pop  data       cnt cr full empty ovf
        vecs[0]  = '{17'h1_0005, 1'b0, 17'h1_0005, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{17'h0_0000, 1'b1, 17'h0_0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{17'h1_0001, 1'b0, 17'h1_0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{17'h1_0002, 1'b0, 17'h1_0001, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{17'h1_0003, 1'b0, 17'h1_0001, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{17'h1_0004, 1'b0, 17'h1_0001, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{17'h1_00FF, 1'b0, 17'h1_0001, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{17'h1_00AA, 1'b1, 17'h1_0002, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{17'h0_0000, 1'b0, 17'h1_0002, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{17'h0_0000, 1'b1, 17'h1_0003, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{17'h0_0000, 1'b1, 17'h1_0004, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{17'h0_0000, 1'b1, 17'h1_00AA, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{17'h0_0000, 1'b1, 17'h0_0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{17'h0_0000, 1'b1, 17'h0_0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{17'h1_0007, 1'b1, 17'h1_0007, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();
        chk_state("reset", 17'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].d, vecs[i].pop);
            chk_state($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_cnt,
                      vecs[i].e_cr, vecs[i].e_full, vecs[i].e_empty, vecs[i].e_ovf);
        end

        // Wrap-around with a scoreboard: pushes 0x10..0x19, pops lagging by two.
        do_reset();
        q.delete();
        credits = 0;
        pops    = 0;
        for (int i = 0; i < 14; i++) begin
            logic [16:0] d;
            logic        p;
            d = (i < 10) ? (17'h1_0010 + 17'(i)) : 17'h0;
            p = (i >= 2);
            data_i = d;
            pop_i  = p;
            #1;
            if (p && q.size() != 0) begin
                chk($sformatf("wrap.head%0d", pops), 32'(data_o), 32'(q.pop_front()));
                pops++;
            end
            if (d[16] && (q.size() < DEPTH)) q.push_back(d);
            @(posedge clk);
            #1;
            if (credit_o) credits++;
            chk($sformatf("wrap.count%0d", i), 32'(count_o), 32'(q.size()));
        end
        step(17'h0, 1'b0);
        if (credit_o) credits++;
        chk("wrap.pops", 32'(pops), 32'd10);
        chk("wrap.credits", 32'(credits), 32'd10);
        chk("wrap.empty", 32'(empty_o), 32'd1);

        // Reset from 3 held flits with overflow set.
        for (int i = 0; i < 5; i++) step(17'h1_0020 + 17'(i), 1'b0);
        step(17'h0, 1'b1);
        chk_state("pre_rst", 17'h1_0021, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        chk_state("post_rst", 17'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(17'h0, 1'b1);
        chk_state("rst_pop", 17'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
